// File: rtl/img_pkg.sv
// Shared definitions for the tagged-pixel datapath: the 35-bit word layout,
// coordinate helpers and the window-generator FSM encoding.
package img_pkg;

  localparam int WORD_W  = 35;
  localparam int VLD_B   = 34;
  localparam int Y_HI    = 33;
  localparam int Y_LO    = 23;
  localparam int X_HI    = 22;
  localparam int X_LO    = 12;
  localparam int PIX_HI  = 11;
  localparam int PIX_LO  = 0;
  localparam int COORD_W = 11;

  typedef logic [WORD_W-1:0]  pix_word_t;
  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN
  } win_state_e;

  function automatic coord_t word_x(input pix_word_t w);
    return w[X_HI:X_LO];
  endfunction

  function automatic coord_t word_y(input pix_word_t w);
    return w[Y_HI:Y_LO];
  endfunction

endpackage

// File: rtl/line_buf.sv
// One raster line of tagged pixels: combinational read, synchronous write.
// Small enough to map to distributed RAM or plain registers.
module line_buf
  import img_pkg::*;
#(
  parameter int DEPTH = 640,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [AW-1:0]   addr_i,
  input  pix_word_t       wdata_i,
  output pix_word_t       rdata_o
);

  pix_word_t mem [DEPTH];

  assign rdata_o = mem[addr_i];

  // NOTE: storage is deliberately not reset; every entry is rewritten while
  // the window fills, and a reset term would block RAM inference.
  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

endmodule

// File: rtl/window_gen.sv
// Builds a 3x3 neighbourhood of tagged pixels from a raster stream using two
// line buffers and a left-shifting register window.
module window_gen
  import img_pkg::*;
#(
  parameter int IMG_W = 640
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  pix_word_t              data_in,
  output logic [0:8][WORD_W-1:0] win,
  output logic                   win_valid,
  output logic                   sync_err
);

  localparam int     LB_AW    = $clog2(IMG_W);
  localparam coord_t LAST_COL = coord_t'(IMG_W - 1);

  win_state_e              state_q, state_d;
  coord_t                  col_q, col_d, exp_y_q, exp_y_d;
  logic [1:0]              row_q, row_d;
  logic [0:8][WORD_W-1:0]  win_q, win_d;
  logic                    win_valid_q, win_valid_d;
  logic                    sync_err_q, sync_err_d;

  logic       frame_start, consume, wrap, mismatch;
  coord_t     eff_col, eff_y;
  logic [1:0] eff_row;
  pix_word_t  o0, o1;

  // A frame-start pixel is consumed as position (0,0) regardless of counters.
  assign frame_start = data_in[VLD_B] && (word_x(data_in) == '0) && (word_y(data_in) == '0);
  assign consume     = data_in[VLD_B] && (frame_start || (state_q != ST_IDLE));
  assign eff_col     = frame_start ? '0 : col_q;
  assign eff_row     = frame_start ? '0 : row_q;
  assign eff_y       = frame_start ? '0 : exp_y_q;
  assign wrap        = (eff_col == LAST_COL);
  assign mismatch    = (word_x(data_in) != col_q) || (word_y(data_in) != exp_y_q);

  line_buf #(.DEPTH(IMG_W)) u_lb0 (
    .clk     (clk),
    .we_i    (consume),
    .addr_i  (eff_col[LB_AW-1:0]),
    .wdata_i (data_in),
    .rdata_o (o0)
  );

  line_buf #(.DEPTH(IMG_W)) u_lb1 (
    .clk     (clk),
    .we_i    (consume),
    .addr_i  (eff_col[LB_AW-1:0]),
    .wdata_i (o0),
    .rdata_o (o1)
  );

  // NOTE: every signal written here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    exp_y_d     = exp_y_q;
    win_d       = win_q;
    win_valid_d = 1'b0;
    sync_err_d  = sync_err_q;

    if (consume) begin
      col_d       = wrap ? '0 : eff_col + coord_t'(1);
      row_d       = (wrap && (eff_row != 2'd2)) ? eff_row + 2'd1 : eff_row;
      exp_y_d     = wrap ? eff_y + coord_t'(1) : eff_y;
      win_valid_d = (eff_row == 2'd2) && (eff_col >= coord_t'(2));
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]   = win_q[3*r+1];
        win_d[3*r+1] = win_q[3*r+2];
      end
      win_d[2] = o1;
      win_d[5] = o0;
      win_d[8] = data_in;
    end

    if (frame_start)            sync_err_d = 1'b0;
    else if (consume && mismatch) sync_err_d = 1'b1;

    unique case (state_q)
      ST_IDLE: if (frame_start) state_d = ST_FILL;
      ST_FILL: if (!frame_start && consume && (row_q == 2'd2) && (col_q == coord_t'(2)))
                 state_d = ST_RUN;
      ST_RUN:  if (frame_start) state_d = ST_FILL;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      exp_y_q     <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      exp_y_q     <= exp_y_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign win       = win_q;
  assign win_valid = win_valid_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_window_gen.sv
// Scoreboard bench for window_gen: drivers queue expected windows, monitors
// pop and compare on every win_valid pulse. Two instances: IMG_W 4 and 640.
module tb_window_gen;
  import img_pkg::*;

  typedef logic [0:8][34:0] win_t;

  logic      clk = 1'b0;
  logic      rst_n;
  pix_word_t din4, din640;
  win_t      win4, win640;
  logic      wv4, wv640, se4, se640;

  always #5 clk = ~clk;

  window_gen #(.IMG_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .data_in(din4),
    .win(win4), .win_valid(wv4), .sync_err(se4)
  );

  window_gen #(.IMG_W(640)) dut640 (
    .clk(clk), .rst_n(rst_n), .data_in(din640),
    .win(win640), .win_valid(wv640), .sync_err(se640)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   first_cyc = -10;
  int   pulses4 = 0;
  int   pulses640 = 0;
  win_t q4[$];
  win_t q640[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [314:0] act, input logic [314:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic pix_word_t tag(input int x, input int y);
    return {1'b1, 11'(y), 11'(x), 12'(16 * y + x)};
  endfunction

  // Window centred on (x-1, y-1) after pixel (x, y): tap 3r+c is (x-2+c, y-2+r).
  function automatic win_t exp_win(input int x, input int y);
    win_t e;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        e[3*r+c] = tag(x - 2 + c, y - 2 + r);
    return e;
  endfunction

  // Monitor for the IMG_W=4 instance, plus the hand-computed first window.
  initial begin
    int   pix_exp [9] = '{0, 1, 2, 16, 17, 18, 32, 33, 34};
    win_t e;
    forever begin
      @(negedge clk);
      if (rst_n && wv4) begin
        pulses4++;
        if (q4.size() == 0) check("spurious_pulse4", wv4, 1'b0);
        else begin
          e = q4.pop_front();
          check("win4", win4, e);
        end
      end
      if (cyc == first_cyc + 1) begin
        check("first_pulse_timing", wv4, 1'b1);
        for (int i = 0; i < 9; i++) check("first_win_pix", win4[i][11:0], 12'(pix_exp[i]));
        check("first_centre_x", win4[4][22:12], 11'd1);
        check("first_centre_y", win4[4][33:23], 11'd1);
      end
    end
  end

  initial begin
    win_t e;
    forever begin
      @(negedge clk);
      if (rst_n && wv640) begin
        pulses640++;
        if (q640.size() == 0) check("spurious_pulse640", wv640, 1'b0);
        else begin
          e = q640.pop_front();
          check("win640", win640, e);
        end
      end
    end
  end

  task automatic drive4(input pix_word_t w);
    @(negedge clk);
    din4 = w;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din4   = '0;
      din640 = '0;
    end
  endtask

  // Full 4x4 frame, optionally with a bubble after every pixel.
  task automatic frame4(input bit bubbles, input bit mark_first);
    bit   stable_pend = 1'b0;
    win_t stable_exp  = '0;
    int   p0 = pulses4;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++) begin
        @(negedge clk);
        if (stable_pend) begin
          check("bubble_hold", win4, stable_exp);
          check("bubble_nopulse", wv4, 1'b0);
          stable_pend = 1'b0;
        end
        din4 = tag(x, y);
        if (x >= 2 && y >= 2) q4.push_back(exp_win(x, y));
        if (mark_first && x == 2 && y == 2) first_cyc = cyc;
        if (bubbles) begin
          @(negedge clk);
          din4 = '0;
          if (x >= 2 && y >= 2) begin
            stable_pend = 1'b1;
            stable_exp  = exp_win(x, y);
          end
        end
      end
    end
    @(negedge clk);
    if (stable_pend) begin
      check("bubble_hold", win4, stable_exp);
      check("bubble_nopulse", wv4, 1'b0);
    end
    din4 = '0;
    idle(3);
    check("pulse_count4", 32'(pulses4 - p0), 32'd4);
    check("queue_drained4", 32'(q4.size()), 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    din4   = '0;
    din640 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset defaults and IDLE ignoring non-frame-start pixels.
    idle(10);
    check("rst_win4", win4, '0);
    check("rst_wv4", wv4, 1'b0);
    check("rst_se4", se4, 1'b0);
    check("rst_win640", win640, '0);
    check("rst_se640", se640, 1'b0);
    drive4(tag(1, 0));
    drive4(tag(2, 2));
    drive4(tag(3, 1));
    idle(2);
    check("idle_ignore_win", win4, '0);
    check("idle_ignore_se", se4, 1'b0);

    // Raster error: x=3 arrives where col=1.
    drive4(tag(0, 0));
    drive4(tag(3, 0));
    drive4('0);
    check("sync_err_set", se4, 1'b1);
    drive4(tag(2, 0));
    drive4(tag(3, 0));
    idle(2);
    check("sync_err_sticky", se4, 1'b1);
    drive4(tag(0, 0));
    drive4('0);
    check("sync_err_cleared", se4, 1'b0);
    idle(2);

    // Clean back-to-back frame, then the same frame with bubbles.
    frame4(1'b0, 1'b1);
    check("clean_no_err", se4, 1'b0);
    frame4(1'b1, 1'b0);

    // Reset after pixel (1,2), leftover pixels must be ignored.
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++)
        if (y < 2 || x < 2) drive4(tag(x, y));
    @(negedge clk);
    din4  = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_win", win4, '0);
    drive4(tag(2, 2));
    drive4(tag(3, 2));
    drive4(tag(1, 3));
    idle(2);
    check("midrst_ignored", win4, '0);
    check("midrst_se", se4, 1'b0);
    frame4(1'b0, 1'b0);

    // Wide image: column must wrap at 639.
    begin
      int p0 = pulses640;
      for (int y = 0; y < 2; y++)
        for (int x = 0; x < 640; x++) begin
          @(negedge clk);
          din640 = tag(x, y);
        end
      @(negedge clk);
      din640 = '0;
      check("wrap640_no_err_row1", se640, 1'b0);
      for (int x = 0; x < 3; x++) begin
        @(negedge clk);
        din640 = tag(x, 2);
        if (x == 2) q640.push_back(exp_win(2, 2));
      end
      idle(3);
      check("pulse_count640", 32'(pulses640 - p0), 32'd1);
      check("queue_drained640", 32'(q640.size()), 32'd0);
      check("wrap640_no_err", se640, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/window_gen.md
# window_gen

Builds the 3×3 neighbourhood consumed by the nine `filter_grid` taps of the edge-detect datapath from a raster-ordered stream of tagged gray pixels. Two line buffers hold the previous two rows. A 3×3 register window shifts once per accepted pixel. Each tap keeps its full 35-bit tag (y, x, pixel) so every downstream `filter_grid` cell can zero border taps by coordinate.

## Interface

Parameters:
- `IMG_W`, default 640: pixels per row. Legal range 3..2047.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `data_in` in 35: tagged pixel. [34] valid, [33:23] y, [22:12] x, [11:0] gray.
- `win` out 9×35: window taps, packed `[0:8][34:0]`.
  - Index = 3·row + col; row 0 is oldest line, col 0 is leftmost.
  - Index 4 is the centre. Each tap keeps the source word format.
- `win_valid` out 1: window complete and updated this cycle.
- `sync_err` out 1: sticky; set when a pixel's x/y disagree with the expected raster position.

## Operation

- **Accepted pixel:** `data_in[34]` = 1. When it is 0, nothing changes and `win_valid` = 0 next cycle.
- **Frame start:** an accepted pixel with x = 0 and y = 0.
  - Clears `col`, `row_cnt` and `sync_err`, and enters FILL.
  - Line-buffer contents are not cleared; they are overwritten during fill.
- **Line buffers:** `lb0` and `lb1`, each `IMG_W` × 35 bits, addressed by `col` (0..IMG_W-1).
  - Read-before-write in the same cycle: read `o0 = lb0[col]` and `o1 = lb1[col]`, then write `lb1[col] ← o0` and `lb0[col] ← data_in`.
- **Window shift:** columns shift left. The new right column (row 0, 1, 2) is {`o1`, `o0`, `data_in`}.
- **Column counter:** `col` increments per accepted pixel and wraps from IMG_W-1 to 0.
  - On wrap, `row_cnt` increments and saturates at 2.
- **Raster check:** the expected position is (`col`, `exp_y`).
  - `exp_y` increments on wrap and is 11 bits wide, wrapping at 2047.
  - A mismatch on a non-frame-start pixel sets `sync_err`.
  - The pixel is still consumed as if it were correct; there is no resync except at frame start.
- **FSM states:** IDLE, FILL, RUN.
  - IDLE: entered at reset. Ignores every pixel until frame start, then goes to FILL.
  - FILL: moves to RUN on the accepted pixel where `row_cnt` = 2 and `col` = 2, i.e. the first pixel completing a full 3×3 window.
  - RUN: frame start returns it to FILL. Otherwise it stays in RUN.
- **win_valid:** asserted for an accepted pixel when `row_cnt` = 2 and (old) `col` ≥ 2, evaluated before the increment.
  - Left-edge positions (col 0, 1 of each row) give `win_valid` = 0; there is no wrap-around windows.
  - The centre tag is then (x-1, y-1) of the incoming pixel.
- **No arithmetic on pixel data.** It passes through unmodified.
- **Simultaneous events:** frame start takes priority over the raster check and over wrap. The frame-start pixel itself is written into the window and into `lb0[0]`.

## Timing

- All outputs are registered. Latency is 1 cycle from an accepted `data_in` to the updated `win` / `win_valid`.
- Throughput is one pixel per cycle with no back-pressure. Upstream may insert bubbles (valid = 0) anywhere.
- Reset values:
  - `win` all '0, `win_valid` 0, `sync_err` 0.
  - `col` 0, `row_cnt` 0, `exp_y` 0, FSM IDLE.
  - Line buffers are not reset.
- Reset asserted mid-frame returns the block to IDLE. Output resumes only after the next frame start plus 2 rows plus 3 pixels.
- `win` holds its value on bubble cycles. `win_valid` is a one-cycle pulse per qualifying pixel.

## Structure

- A shared package `img_pkg` holds:
  - the 35-bit pixel word typedef;
  - field localparams: valid bit 34, Y [33:23], X [22:12], PIX [11:0];
  - the FSM enum.
- Sub-module `line_buf`: a parameterised depth × 35 array with a combinational read port and a synchronous write port.
  - It is instantiated twice and maps to distributed RAM or registers.

## Test plan

- **Reset defaults:** reset with `IMG_W` = 4, then drive valid = 0 for 10 cycles. Expect all outputs 0, IDLE, and no `win_valid`.
- **Clean frame:** a clean 4×4 frame with pix = 16·y + x, streamed back-to-back.
  - Expect the first `win_valid` one cycle after pixel (2,2).
  - That window should be 0, 1, 2, 16, 17, 18, 32, 33, 34, with centre tag (1,1).
  - Expect exactly 4 pulses in total.
- **Bubbles:** the same frame with a valid = 0 bubble after every pixel. Expect identical window contents and pulse count, with `win` stable during bubbles.
- **Raster error:** drive pixel x = 3 where `col` = 1 in row 0. Expect `sync_err` = 1 next cycle and held; the next frame start clears it.
- **Reset mid-frame:** reset after pixel (1,2) of a frame, then restart the frame. Expect no `win_valid` until (2,2) of the new frame, and correct contents.
- **Row wrap:** with `IMG_W` = 640, check that `col` wraps at 639 and that the window at x = 2 of row 2 contains the tags of x = 0..2 from rows 0..2.
